// File: rtl/dma_pkg.sv
// Shared definitions for the IFFT DMA transmit/receive paths.
// State encoding and default stream geometry.
package dma_pkg;

  localparam int DMA_DATA_W         = 64;
  localparam int DMA_SAMPLES_PER_CH = 8192;

  typedef enum logic [2:0] {
    WAIT_RAM = 3'd0,
    IDLE     = 3'd1,
    CH_A     = 3'd2,
    CH_B     = 3'd3,
    DRAIN    = 3'd4
  } dma_state_e;

  function automatic logic is_busy(dma_state_e s);
    return (s == CH_A) || (s == CH_B) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/axis_skid.sv
// Two-entry full-throughput skid buffer with registered input ready.
// Output register plus one overflow slot; order preserved.
module axis_skid
  import dma_pkg::*;
#(
  parameter int DATA_W = DMA_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_vld_i,
  output logic              in_rdy_o,
  input  logic [DATA_W-1:0] in_dat_i,
  output logic              out_vld_o,
  input  logic              out_rdy_i,
  output logic [DATA_W-1:0] out_dat_o,
  output logic              empty_o
);

  logic              out_vld_q, out_vld_d;
  logic [DATA_W-1:0] out_dat_q, out_dat_d;
  logic              sk_vld_q, sk_vld_d;
  logic [DATA_W-1:0] sk_dat_q, sk_dat_d;
  logic              rdy_q, rdy_d;
  logic              push, pop;

  assign push = in_vld_i & rdy_q;
  assign pop  = out_vld_q & out_rdy_i;

  always_comb begin
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    sk_vld_d  = sk_vld_q;
    sk_dat_d  = sk_dat_q;
    if (!out_vld_q || pop) begin
      if (sk_vld_q) begin
        out_vld_d = 1'b1;
        out_dat_d = sk_dat_q;
        sk_vld_d  = 1'b0;
      end else if (push) begin
        out_vld_d = 1'b1;
        out_dat_d = in_dat_i;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (push) begin
      // Output stalled: park the beat in the overflow slot.
      sk_vld_d = 1'b1;
      sk_dat_d = in_dat_i;
    end
    rdy_d = !sk_vld_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      sk_vld_q  <= 1'b0;
      sk_dat_q  <= '0;
      rdy_q     <= 1'b1;
    end else begin
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
      sk_vld_q  <= sk_vld_d;
      sk_dat_q  <= sk_dat_d;
      rdy_q     <= rdy_d;
    end
  end

  assign in_rdy_o  = rdy_q;
  assign out_vld_o = out_vld_q;
  assign out_dat_o = out_dat_q;
  assign empty_o   = !out_vld_q && !sk_vld_q;

endmodule

// File: rtl/dma_tx.sv
// DMA MM2S burst splitter: first half to IFFT A, second half to IFFT B.
// Define DMA_TX_TLAST_CHK_EN to enable sticky tlast framing check.
module dma_tx
  import dma_pkg::*;
#(
  parameter int DATA_W         = DMA_DATA_W,
  parameter int SAMPLES_PER_CH = DMA_SAMPLES_PER_CH
) (
  input  logic              clk_dma,
  input  logic              arst,
  input  logic              start_tx_dma,
  input  logic              s_axi_dma_tvld,
  output logic              s_axi_dma_trdy,
  input  logic [DATA_W-1:0] s_axi_dma_tdat,
  input  logic              s_axi_dma_tlast,
  output logic              iffta_dma_axi_tvld,
  input  logic              iffta_dma_axi_trdy,
  output logic [DATA_W-1:0] iffta_dma_axi_tdat,
  input  logic              iffta_ram_rdy,
  output logic              ifftb_dma_axi_tvld,
  input  logic              ifftb_dma_axi_trdy,
  output logic [DATA_W-1:0] ifftb_dma_axi_tdat,
  input  logic              ifftb_ram_rdy,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tlast_err
);

  localparam int CNT_W = $clog2(SAMPLES_PER_CH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_CH - 1);

  dma_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, done_q, done_d, err_q, err_d;
  logic             rdy_a, rdy_b, empty_a, empty_b;
  logic             in_a, in_b;
  logic             acc, last_beat;

  // Ready comes only from state and registered skid ready.
  assign s_axi_dma_trdy = ((state_q == CH_A) && rdy_a)
                       || ((state_q == CH_B) && rdy_b);
  assign acc       = s_axi_dma_tvld && s_axi_dma_trdy;
  assign last_beat = (cnt_q == CNT_LAST);
  assign in_a      = s_axi_dma_tvld && (state_q == CH_A);
  assign in_b      = s_axi_dma_tvld && (state_q == CH_B);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      WAIT_RAM: begin
        if (iffta_ram_rdy && ifftb_ram_rdy) state_d = IDLE;
      end
      IDLE: begin
        if (start_tx_dma) state_d = CH_A;
      end
      CH_A, CH_B: begin
        if (acc) begin
          cnt_d = last_beat ? '0 : cnt_q + 1'b1;
          if (last_beat) state_d = (state_q == CH_A) ? CH_B : DRAIN;
        end
      end
      DRAIN: begin
        if (empty_a && empty_b) begin
          state_d = WAIT_RAM;
          done_d  = 1'b1;
        end
      end
      default: state_d = WAIT_RAM;
    endcase
  end

`ifdef DMA_TX_TLAST_CHK_EN
  assign err_d = err_q || (acc && (s_axi_dma_tlast != last_beat));
`else
  logic unused_tlast;
  assign unused_tlast = s_axi_dma_tlast;
  assign err_d        = 1'b0;
`endif

  always_ff @(posedge clk_dma or posedge arst) begin
    if (arst) begin
      state_q <= WAIT_RAM;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= is_busy(state_d);
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  axis_skid #(.DATA_W(DATA_W)) skid_a (
    .clk_i     (clk_dma),
    .rst_i     (arst),
    .in_vld_i  (in_a),
    .in_rdy_o  (rdy_a),
    .in_dat_i  (s_axi_dma_tdat),
    .out_vld_o (iffta_dma_axi_tvld),
    .out_rdy_i (iffta_dma_axi_trdy),
    .out_dat_o (iffta_dma_axi_tdat),
    .empty_o   (empty_a)
  );

  axis_skid #(.DATA_W(DATA_W)) skid_b (
    .clk_i     (clk_dma),
    .rst_i     (arst),
    .in_vld_i  (in_b),
    .in_rdy_o  (rdy_b),
    .in_dat_i  (s_axi_dma_tdat),
    .out_vld_o (ifftb_dma_axi_tvld),
    .out_rdy_i (ifftb_dma_axi_trdy),
    .out_dat_o (ifftb_dma_axi_tdat),
    .empty_o   (empty_b)
  );

  assign tx_busy   = busy_q;
  assign tx_done   = done_q;
  assign tlast_err = err_q;

endmodule

// File: tb/tb_dma_tx.sv
// Randomized bench for dma_tx with a queue-based split model.
// Beats 0..SPC-1 of a transfer belong to A, the rest to B.
module tb_dma_tx;

  localparam int DW  = 64;
  localparam int SPC = 16;
  localparam int NB  = 2 * SPC;
`ifdef DMA_TX_TLAST_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          arst = 1'b0;
  logic          start = 1'b0;
  logic          s_tvld = 1'b0;
  logic          s_trdy;
  logic [DW-1:0] s_tdat = '0;
  logic          s_tlast = 1'b0;
  logic          a_tvld, b_tvld;
  logic          a_trdy = 1'b0, b_trdy = 1'b0;
  logic [DW-1:0] a_tdat, b_tdat;
  logic          a_ram = 1'b0, b_ram = 1'b0;
  logic          tx_busy, tx_done, tlast_err;

  always #5 clk = ~clk;

  dma_tx #(.DATA_W(DW), .SAMPLES_PER_CH(SPC)) dut (
    .clk_dma            (clk),
    .arst               (arst),
    .start_tx_dma       (start),
    .s_axi_dma_tvld     (s_tvld),
    .s_axi_dma_trdy     (s_trdy),
    .s_axi_dma_tdat     (s_tdat),
    .s_axi_dma_tlast    (s_tlast),
    .iffta_dma_axi_tvld (a_tvld),
    .iffta_dma_axi_trdy (a_trdy),
    .iffta_dma_axi_tdat (a_tdat),
    .iffta_ram_rdy      (a_ram),
    .ifftb_dma_axi_tvld (b_tvld),
    .ifftb_dma_axi_trdy (b_trdy),
    .ifftb_dma_axi_tdat (b_tdat),
    .ifftb_ram_rdy      (b_ram),
    .tx_busy            (tx_busy),
    .tx_done            (tx_done),
    .tlast_err          (tlast_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  int xfer_acc = 0, rx_a = 0, rx_b = 0, done_cnt = 0;
  int cyc = 0, t15 = 0, t16 = 0;
  bit acc_now = 0, stall_a = 0, stall_b = 0;
  logic [DW-1:0] sa_dat, sb_dat;
  int gap_pct = 0, alo_pct = 0, blo_pct = 0, bad_idx = -1;
  bit seq_dat = 0, comb_chk = 0, err_exp = 0;

  always @(negedge clk) begin
    cyc++;
    acc_now = 0;
    if (arst) begin
      stall_a = 0;
      stall_b = 0;
    end else begin
      if (s_tvld && s_trdy) begin
        if (xfer_acc < SPC) qa.push_back(s_tdat);
        else qb.push_back(s_tdat);
        if (xfer_acc == SPC - 1) t15 = cyc;
        if (xfer_acc == SPC) t16 = cyc;
        xfer_acc++;
        acc_now = 1;
      end
      if (stall_a) begin
        check("a_hold_vld", a_tvld, 1);
        check("a_hold_dat", a_tdat, sa_dat);
      end
      if (stall_b) begin
        check("b_hold_vld", b_tvld, 1);
        check("b_hold_dat", b_tdat, sb_dat);
      end
      if (a_tvld && a_trdy) begin
        if (qa.size() == 0) check("a_extra", 1, 0);
        else check("a_data", a_tdat, qa.pop_front());
        rx_a++;
      end
      if (b_tvld && b_trdy) begin
        if (qb.size() == 0) check("b_extra", 1, 0);
        else check("b_data", b_tdat, qb.pop_front());
        rx_b++;
      end
      stall_a = a_tvld && !a_trdy;
      stall_b = b_tvld && !b_trdy;
      sa_dat  = a_tdat;
      sb_dat  = b_tdat;
      if (tx_done) done_cnt++;
    end
  end

  task automatic drive_cycle(input bit force_a);
    logic t;
    @(posedge clk);
    #1;
    if (!(s_tvld && !acc_now)) begin
      s_tvld  = (xfer_acc < NB) && ($urandom_range(99) >= gap_pct);
      s_tdat  = seq_dat ? 64'(xfer_acc) : {$urandom, $urandom};
      s_tlast = ((xfer_acc % SPC) == SPC - 1) ^ (xfer_acc == bad_idx);
    end
    a_trdy = !force_a && ($urandom_range(99) >= alo_pct);
    b_trdy = ($urandom_range(99) >= blo_pct);
    if (comb_chk) begin
      #1 t = s_trdy;
      a_trdy = !a_trdy;
      b_trdy = !b_trdy;
      #1 check("trdy_comb", s_trdy, t);
      a_trdy = !a_trdy;
      b_trdy = !b_trdy;
    end
  endtask

  task automatic run_xfer(input int rst_at, input int hold_a);
    int cnt;
    bit aborted;
    xfer_acc = 0;
    rx_a = 0;
    rx_b = 0;
    done_cnt = 0;
    t15 = 0;
    t16 = 0;
    aborted = 0;
    repeat (2) @(posedge clk);
    #1 start = 1;
    cnt = 0;
    while (done_cnt == 0 && cnt < 3000 && !aborted) begin
      if (hold_a > 0 && cnt == hold_a) begin
        check("hold_acc", 64'(xfer_acc), 64'(2));
        check("hold_trdy", s_trdy, 0);
      end
      drive_cycle(cnt < hold_a);
      start = 0;
      cnt++;
      if (rst_at > 0 && xfer_acc >= rst_at) begin
        arst = 1;
        #1;
        check("rst_a_vld", a_tvld, 0);
        check("rst_b_vld", b_tvld, 0);
        check("rst_s_trdy", s_trdy, 0);
        check("rst_busy", tx_busy, 0);
        s_tvld = 0;
        a_trdy = 0;
        b_trdy = 0;
        repeat (2) @(posedge clk);
        #1 arst = 0;
        qa.delete();
        qb.delete();
        err_exp = 0;
        aborted = 1;
      end
    end
    if (!aborted) begin
      check("xfer_done", 64'(done_cnt != 0), 1);
      s_tvld = 0;
      a_trdy = 1;
      b_trdy = 1;
      repeat (4) @(negedge clk);
      check("rx_a_cnt", 64'(rx_a), 64'(SPC));
      check("rx_b_cnt", 64'(rx_b), 64'(SPC));
      check("done_once", 64'(done_cnt), 1);
      check("qa_empty", 64'(qa.size()), 0);
      check("qb_empty", 64'(qb.size()), 0);
      check("busy_end", tx_busy, 0);
      check("tlast_err", tlast_err, err_exp);
    end
  endtask

  initial begin
    #1 arst = 1;
    #1;
    check("rst_s_trdy", s_trdy, 0);
    check("rst_a_vld", a_tvld, 0);
    check("rst_b_vld", b_tvld, 0);
    check("rst_a_dat", a_tdat, 0);
    check("rst_b_dat", b_tdat, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_err", tlast_err, 0);
    repeat (2) @(posedge clk);
    #1 arst = 0;

    // Only A RAM ready: start must be ignored.
    a_ram = 1;
    s_tvld = 1;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (6) @(negedge clk);
    check("ram_busy", tx_busy, 0);
    check("ram_trdy", s_trdy, 0);
    check("ram_acc", 64'(xfer_acc), 0);
    s_tvld = 0;
    b_ram = 1;

    // Full rate, sequential data.
    seq_dat = 1;
    run_xfer(0, 0);
    check("ab_gap", 64'(t16 - t15), 1);
    seq_dat = 0;

    // Random backpressure and source gaps.
    gap_pct = 25;
    alo_pct = 30;
    blo_pct = 30;
    comb_chk = 1;
    for (int i = 0; i < 3; i++) run_xfer(0, 0);
    comb_chk = 0;

    // Channel A blocked for the start of CH_A.
    gap_pct = 0;
    alo_pct = 0;
    blo_pct = 0;
    run_xfer(0, 12);

    // Reset during beat 20, then a clean transfer.
    run_xfer(20, 0);
    repeat (2) @(negedge clk);
    check("post_rst_busy", tx_busy, 0);
    check("post_rst_trdy", s_trdy, 0);
    run_xfer(0, 0);

    // Spurious tlast on beat 9.
    gap_pct = 20;
    alo_pct = 30;
    blo_pct = 30;
    bad_idx = 9;
    err_exp = CHK;
    run_xfer(0, 0);
    bad_idx = -1;
    repeat (5) @(negedge clk);
    check("tlast_sticky", tlast_err, err_exp);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_tx.md
Name: dma_tx

Overview:
- Transmit-side counterpart of the IFFT DMA receive path.
- Accepts one AXI-Stream burst from the DMA engine (MM2S).
- Delivers the first SAMPLES_PER_CH beats to IFFT channel A and the next SAMPLES_PER_CH beats to IFFT channel B.
- Each channel output passes through its own full-throughput skid buffer, so IFFT-side ready never combinationally reaches the DMA-side ready.

Parameters:
- DATA_W, 64, stream data width.
- SAMPLES_PER_CH, 8192, beats per channel per transfer; power of two, at least 2.

Ports:
- clk_dma  in  1  single clock domain.
- arst  in  1  asynchronous reset, active-high.
- start_tx_dma  in  1  level/pulse; arms one A+B transfer.
- s_axi_dma_tvld  in  1  DMA stream valid.
- s_axi_dma_trdy  out  1  DMA stream ready.
- s_axi_dma_tdat  in  DATA_W  DMA stream data.
- s_axi_dma_tlast  in  1  DMA end-of-channel marker (used only with the optional feature).
- iffta_dma_axi_tvld  out  1  channel A valid.
- iffta_dma_axi_trdy  in  1  channel A ready.
- iffta_dma_axi_tdat  out  DATA_W  channel A data.
- iffta_ram_rdy  in  1  channel A input RAM able to take a frame.
- ifftb_dma_axi_tvld  out  1  channel B valid.
- ifftb_dma_axi_trdy  in  1  channel B ready.
- ifftb_dma_axi_tdat  out  DATA_W  channel B data.
- ifftb_ram_rdy  in  1  channel B input RAM able to take a frame.
- tx_busy  out  1  high in CH_A, CH_B, DRAIN.
- tx_done  out  1  one-cycle pulse at end of transfer.
- tlast_err  out  1  sticky framing error.

Behaviour:
- Reset (arst high, asynchronous):
  - state = WAIT_RAM; counter = 0.
  - Both skid buffers emptied, contents discarded.
  - All outputs 0: s_axi_dma_trdy, both tvld, tx_busy, tx_done, tlast_err. tdat outputs are 0.
  - Reset mid-transfer aborts the transfer; no partial-frame recovery.
- State machine, one transition per cycle:
  - WAIT_RAM: go to IDLE when iffta_ram_rdy & ifftb_ram_rdy.
  - IDLE: go to CH_A when start_tx_dma. start_tx_dma is ignored in every other state.
  - CH_A: s_axi_dma_trdy = skid_a input-ready. Each accepted beat (tvld & trdy) is written to skid_a and counter increments. On the accepted beat with counter == SAMPLES_PER_CH-1: counter <= 0, go to CH_B.
  - CH_B: same as CH_A, using skid_b. The last beat goes to DRAIN.
  - DRAIN: s_axi_dma_trdy = 0. When both skids are empty: tx_done = 1 for one cycle, then WAIT_RAM.
- s_axi_dma_trdy is 0 in WAIT_RAM, IDLE and DRAIN. It is driven only from registered skid state and state bits, never from the iffta/ifftb trdy inputs.
- Counter width is $clog2(SAMPLES_PER_CH). It wraps to 0 exactly at the channel boundary, so no beat is dropped or duplicated across the A/B switch.
- The A-to-B switch has zero bubble: the last A beat and the first B beat may be accepted on consecutive cycles.
- Skid buffer (2 entries):
  - Full throughput.
  - Output latency 1 cycle from input acceptance to tvld.
  - Input-ready is registered: high while at most 1 entry is occupied, or when draining in the same cycle.
  - Data order is preserved.
  - While tvld is high without trdy, tvld and tdat stay stable.
- iffta/ifftb tvld may still be high while the FSM is already in the other channel state or in DRAIN. This is legal.
- *_ram_rdy is sampled only in WAIT_RAM. A deassertion mid-transfer is ignored.
- tx_busy is registered from state.

Optional Feature:
- Macro DMA_TX_TLAST_CHK_EN.
- Defined:
  - On every accepted beat, compare s_axi_dma_tlast with (counter == SAMPLES_PER_CH-1).
  - On a mismatch, tlast_err sets to 1 and stays set until reset.
  - Data flow is unchanged: no early channel switch, no drop.
- Not defined: s_axi_dma_tlast is ignored and tlast_err is tied to 0.

Decomposition:
- Shared package dma_pkg holds:
  - the state encoding: WAIT_RAM=3'd0, IDLE=3'd1, CH_A=3'd2, CH_B=3'd3, DRAIN=3'd4;
  - the default DATA_W and SAMPLES_PER_CH constants, which dma_rx also imports.
- One sub-module, axis_skid (parameter DATA_W), instantiated twice (skid_a, skid_b).
- The FSM and counter stay in dma_tx.

Test Plan:
Use SAMPLES_PER_CH=16 for all scenarios.
- Both ram_rdy=1, pulse start, DMA streams 0..31 with both IFFT trdy=1 -> channel A receives 0..15, channel B receives 16..31, no gap at 15/16, tx_done pulses once, back to WAIT_RAM.
- Only iffta_ram_rdy=1, then start -> stays in WAIT_RAM, s_axi_dma_trdy=0. Assert ifftb_ram_rdy=1, then start -> transfer runs.
- Random IFFT trdy backpressure (30% low) and random DMA tvld gaps -> data order and count exact, tdat stable while stalled, s_axi_dma_trdy never combinationally follows iffta/ifftb trdy.
- iffta trdy=0 for the whole of CH_A -> exactly 2 beats accepted, then s_axi_dma_trdy=0. Release -> remaining 14 beats flow.
- arst asserted at beat 20 -> all tvld/trdy go to 0 immediately. After release: state WAIT_RAM, counter 0; a new full transfer is correct.
- With DMA_TX_TLAST_CHK_EN defined: tlast on beat 9 -> tlast_err=1 and sticky, data still split 16/16. Without the macro: tlast_err stays 0.
